// File: rtl/chmu_pkg.sv
// Shared types for the CHMU request arbiter: FSM states, grant sources and
// the saturating statistics increment.
package chmu_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        QUERY = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } grant_src_e;

    localparam int STAT_W = 32;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                  input logic              en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/chmu_wrr_sel.sv
// Weighted round-robin selector between read and write page addresses.
// Credits only move on a granted cycle; a lone requester clears both credits.
module chmu_wrr_sel
    import chmu_pkg::*;
#(
    parameter int RD_WEIGHT = 3,
    parameter int WR_WEIGHT = 1,
    parameter int CREDIT_W  = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en_i,
    input  logic       rd_valid_i,
    input  logic       wr_valid_i,
    output logic       grant_rd_o,
    output logic       grant_wr_o,
    output grant_src_e src_o
);

    localparam logic [CREDIT_W-1:0] RD_W = CREDIT_W'(RD_WEIGHT);
    localparam logic [CREDIT_W-1:0] WR_W = CREDIT_W'(WR_WEIGHT);

    logic [CREDIT_W-1:0] rd_cred_q, rd_cred_d;
    logic [CREDIT_W-1:0] wr_cred_q, wr_cred_d;

    always_comb begin
        src_o     = NONE;
        rd_cred_d = rd_cred_q;
        wr_cred_d = wr_cred_q;
        if (en_i) begin
            case ({rd_valid_i, wr_valid_i})
                2'b10: begin
                    src_o     = RD;
                    rd_cred_d = '0;
                    wr_cred_d = '0;
                end
                2'b01: begin
                    src_o     = WR;
                    rd_cred_d = '0;
                    wr_cred_d = '0;
                end
                2'b11: begin
                    if (rd_cred_q < RD_W) begin
                        src_o     = RD;
                        rd_cred_d = rd_cred_q + 1'b1;
                    end else if (wr_cred_q < WR_W) begin
                        src_o     = WR;
                        wr_cred_d = wr_cred_q + 1'b1;
                    end else begin
                        // both exhausted cannot persist; restart the round on read
                        src_o     = RD;
                        rd_cred_d = CREDIT_W'(1);
                        wr_cred_d = '0;
                    end
                    if ((rd_cred_d == RD_W) && (wr_cred_d == WR_W)) begin
                        rd_cred_d = '0;
                        wr_cred_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant_rd_o = (src_o == RD);
    assign grant_wr_o = (src_o == WR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cred_q <= '0;
            wr_cred_q <= '0;
        end else begin
            rd_cred_q <= rd_cred_d;
            wr_cred_q <= wr_cred_d;
        end
    end

endmodule

// File: rtl/chmu_req_arbiter.sv
// Shares the CHMU tracker address input between read/write address streams
// and CSR hot-list queries. Statistics counters built when CHMU_ARB_STATS_EN.
module chmu_req_arbiter
    import chmu_pkg::*;
#(
    parameter int ADDR_SIZE = 21,
    parameter int RD_WEIGHT = 3,
    parameter int WR_WEIGHT = 1,
    parameter int CREDIT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rd_valid,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 rd_ready,
    input  logic                 wr_valid,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    output logic                 wr_ready,
    output logic [ADDR_SIZE-1:0] trk_addr,
    output logic                 trk_valid,
    input  logic                 trk_ready,
    input  logic                 query_req,
    output logic                 query_en,
    input  logic                 query_ready,
    output logic                 query_done,
    output logic                 busy,
    output logic [31:0]          stat_rd_grants,
    output logic [31:0]          stat_wr_grants,
    output logic [31:0]          stat_stall_cycles
);

    arb_state_e           state_q, state_d;
    logic                 query_pend_q, query_pend_d;
    logic                 trk_valid_q, trk_valid_d;
    logic [ADDR_SIZE-1:0] trk_addr_q, trk_addr_d;
    logic                 load_ok, arb_en, grant_rd, grant_wr;
    grant_src_e           src;

    assign load_ok = ~trk_valid_q | trk_ready;
    assign arb_en  = (state_q == ARB) & load_ok & ~query_pend_q;

    chmu_wrr_sel #(
        .RD_WEIGHT (RD_WEIGHT),
        .WR_WEIGHT (WR_WEIGHT),
        .CREDIT_W  (CREDIT_W)
    ) u_wrr (
        .clk        (clk),
        .rstn       (rstn),
        .en_i       (arb_en),
        .rd_valid_i (rd_valid),
        .wr_valid_i (wr_valid),
        .grant_rd_o (grant_rd),
        .grant_wr_o (grant_wr),
        .src_o      (src)
    );

    assign rd_ready = grant_rd;
    assign wr_ready = grant_wr;

    always_comb begin
        trk_valid_d = trk_valid_q;
        trk_addr_d  = trk_addr_q;
        case (src)
            RD: begin
                trk_valid_d = 1'b1;
                trk_addr_d  = rd_addr;
            end
            WR: begin
                trk_valid_d = 1'b1;
                trk_addr_d  = wr_addr;
            end
            default: if (trk_ready) trk_valid_d = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        query_en   = 1'b0;
        query_done = 1'b0;
        case (state_q)
            ARB:   if (query_pend_q) state_d = DRAIN;
            // the last beat may be accepted in the same cycle we leave
            DRAIN: if (load_ok) state_d = QUERY;
            QUERY: begin
                query_en = 1'b1;
                if (query_ready) begin
                    query_done = 1'b1;
                    state_d    = ARB;
                end
            end
            default: state_d = ARB;
        endcase
        query_pend_d = query_req | (query_pend_q & ~query_done);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ARB;
            query_pend_q <= 1'b0;
            trk_valid_q  <= 1'b0;
            trk_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            query_pend_q <= query_pend_d;
            trk_valid_q  <= trk_valid_d;
            trk_addr_q   <= trk_addr_d;
        end
    end

    assign trk_valid = trk_valid_q;
    assign trk_addr  = trk_addr_q;
    assign busy      = query_pend_q | (state_q != ARB);

`ifdef CHMU_ARB_STATS_EN
    logic [STAT_W-1:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            rd_cnt_q    <= sat_inc(rd_cnt_q, grant_rd);
            wr_cnt_q    <= sat_inc(wr_cnt_q, grant_wr);
            stall_cnt_q <= sat_inc(stall_cnt_q, trk_valid_q & ~trk_ready);
        end
    end

    assign stat_rd_grants    = rd_cnt_q;
    assign stat_wr_grants    = wr_cnt_q;
    assign stat_stall_cycles = stall_cnt_q;
`else
    assign stat_rd_grants    = '0;
    assign stat_wr_grants    = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_chmu_req_arbiter.sv
// Directed scoreboard bench for chmu_req_arbiter: stimulus pushes expected
// tracker addresses, a negedge monitor pops them on every tracker handshake.
module tb_chmu_req_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rd_valid, wr_valid, trk_ready, query_req, query_ready;
    logic [20:0] rd_addr, wr_addr;
    logic        rd_ready, wr_ready, trk_valid, query_en, query_done, busy;
    logic [20:0] trk_addr;
    logic [31:0] stat_rd_grants, stat_wr_grants, stat_stall_cycles;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic [20:0] exp_q[$];

    always #5 clk = ~clk;

    chmu_req_arbiter dut (
        .clk               (clk),
        .rstn              (rstn),
        .rd_valid          (rd_valid),
        .rd_addr           (rd_addr),
        .rd_ready          (rd_ready),
        .wr_valid          (wr_valid),
        .wr_addr           (wr_addr),
        .wr_ready          (wr_ready),
        .trk_addr          (trk_addr),
        .trk_valid         (trk_valid),
        .trk_ready         (trk_ready),
        .query_req         (query_req),
        .query_en          (query_en),
        .query_ready       (query_ready),
        .query_done        (query_done),
        .busy              (busy),
        .stat_rd_grants    (stat_rd_grants),
        .stat_wr_grants    (stat_wr_grants),
        .stat_stall_cycles (stat_stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (trk_valid && trk_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", {11'd0, trk_addr}, 32'hdead);
                else chk("trk_addr_order", {11'd0, trk_addr}, {11'd0, exp_q.pop_front()});
            end
            if (query_en) chk("query_overlap", {31'd0, trk_valid}, 32'd0);
            if (query_done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          idx, rd_idx, wr_idx, n_gr, d0;
        logic        lat_pend;
        logic [20:0] lat_addr;

        rstn = 1'b0; rd_valid = 0; wr_valid = 0; trk_ready = 0;
        query_req = 0; query_ready = 0; rd_addr = '0; wr_addr = '0;
        #12;
        chk("rst_trk_valid", {31'd0, trk_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_query_en", {31'd0, query_en}, 0);
        chk("rst_stat_rd", stat_rd_grants, 0);
        step();
        rstn = 1'b1;
        step();

        // read-only stream, back-to-back with latency 1
        trk_ready = 1; rd_valid = 1; rd_addr = 21'h10; idx = 0; lat_pend = 0; lat_addr = '0;
        for (int k = 0; k < 5; k++) exp_q.push_back(21'h10 + 21'(k));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rdonly_wr_ready", {31'd0, wr_ready}, 0);
            if (lat_pend) chk("rdonly_latency", {10'd0, trk_valid, trk_addr}, {10'd0, 1'b1, lat_addr});
            lat_pend = 0;
            if (idx < 5) begin
                chk("rdonly_b2b", {31'd0, rd_ready}, 1);
                if (rd_ready) begin lat_pend = 1; lat_addr = rd_addr; idx++; end
            end
            step();
            if (idx >= 5) rd_valid = 0;
            else rd_addr = 21'h10 + 21'(idx);
        end

        // both streams valid: R,R,R,W pattern over 40 grants
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 3; j++) exp_q.push_back(21'h100 + 21'(3*k + j));
            exp_q.push_back(21'h200 + 21'(k));
        end
        rd_idx = 0; wr_idx = 0; n_gr = 0;
        rd_valid = 1; wr_valid = 1; rd_addr = 21'h100; wr_addr = 21'h200;
        for (int c = 0; c < 100 && n_gr < 40; c++) begin
            @(negedge clk);
            chk("wrr_rd", {31'd0, rd_ready}, {31'd0, (n_gr % 4) < 3});
            chk("wrr_wr", {31'd0, wr_ready}, {31'd0, (n_gr % 4) == 3});
            if (rd_ready) rd_idx++;
            if (wr_ready) wr_idx++;
            n_gr = rd_idx + wr_idx;
            step();
            rd_addr = 21'h100 + 21'(rd_idx);
            wr_addr = 21'h200 + 21'(wr_idx);
            if (n_gr >= 40) begin rd_valid = 0; wr_valid = 0; end
        end
        chk("wrr_total", n_gr, 40);
        chk("wrr_reads", rd_idx, 30);
        chk("wrr_writes", wr_idx, 10);
        step(); step();

        // backpressure: hold 0x1ABCD for 5 cycles
        trk_ready = 0; rd_valid = 1; rd_addr = 21'h1ABCD; exp_q.push_back(21'h1ABCD);
        @(negedge clk);
        chk("stall_first_grant", {31'd0, rd_ready}, 1);
        step();
        rd_addr = 21'h1FFFF; exp_q.push_back(21'h1FFFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_addr", {10'd0, trk_valid, trk_addr}, {10'd0, 1'b1, 21'h1ABCD});
            chk("stall_no_grant", {30'd0, rd_ready, wr_ready}, 0);
            step();
        end
        trk_ready = 1;
        @(negedge clk);
        chk("stall_release_grant", {31'd0, rd_ready}, 1);
`ifdef CHMU_ARB_STATS_EN
        chk("stat_stall", stat_stall_cycles, 5);
        chk("stat_rd", stat_rd_grants, 36);
        chk("stat_wr", stat_wr_grants, 10);
`else
        chk("stat_stall_off", stat_stall_cycles, 0);
        chk("stat_rd_off", stat_rd_grants, 0);
`endif
        step();
        rd_valid = 0;
        step(); step();

        // query while a beat is stuck: drain, then query handshake
        trk_ready = 0; rd_valid = 1; rd_addr = 21'h2222; exp_q.push_back(21'h2222);
        step();
        rd_addr = 21'h3333; exp_q.push_back(21'h3333); query_req = 1;
        @(negedge clk);
        chk("q_blocked", {31'd0, rd_ready}, 0);
        step();
        query_req = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("q_drain_no_grant", {31'd0, rd_ready}, 0);
            chk("q_drain_no_en", {31'd0, query_en}, 0);
            chk("q_drain_busy", {31'd0, busy}, 1);
            step();
        end
        trk_ready = 1; d0 = done_cnt;
        @(negedge clk);
        chk("q_drain_last_no_grant", {31'd0, rd_ready}, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("q_en_held", {31'd0, query_en}, 1);
            chk("q_done_idle", {31'd0, query_done}, 0);
            chk("q_no_grant", {31'd0, rd_ready}, 0);
            step();
        end
        query_ready = 1;
        @(negedge clk);
        chk("q_done_pulse", {31'd0, query_done}, 1);
        step();
        query_ready = 0;
        @(negedge clk);
        chk("q_done_single", {31'd0, query_done}, 0);
        chk("q_resume_grant", {31'd0, rd_ready}, 1);
        chk("q_resume_busy", {31'd0, busy}, 0);
        step();
        rd_valid = 0;
        step();
        chk("q_done_count", done_cnt - d0, 1);

        // query_req held: back-to-back queries, busy never drops
        query_req = 1; query_ready = 1; d0 = done_cnt;
        step();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("qh_busy", {31'd0, busy}, 1);
            chk("qh_en_phase", {31'd0, query_en}, {31'd0, (i % 3) == 2});
            step();
        end
        query_req = 0;
        step(); step(); step();
        @(negedge clk);
        chk("qh_idle_busy", {31'd0, busy}, 0);
        step();
        chk("qh_done_count", done_cnt - d0, 4);
        query_ready = 0;

        // reset while in QUERY
        query_req = 1;
        step();
        query_req = 0;
        step(); step();
        @(negedge clk);
        chk("rq_in_query", {31'd0, query_en}, 1);
        d0 = done_cnt;
        #2 rstn = 0;
        #1;
        chk("rq_en_cleared", {31'd0, query_en}, 0);
        chk("rq_valid_cleared", {31'd0, trk_valid}, 0);
        chk("rq_busy_cleared", {31'd0, busy}, 0);
        step(); step();
        rstn = 1;
        trk_ready = 1; rd_valid = 1; rd_addr = 21'h0ABCD; exp_q.push_back(21'h0ABCD);
        @(negedge clk);
        chk("rq_first_grant", {31'd0, rd_ready}, 1);
        step();
        rd_valid = 0;
        step();
        chk("rq_no_done", done_cnt - d0, 0);

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
